updi_instruction_arbiter: RTL and testbench
===========================================

Name: updi_instruction_arbiter

Overview:
- Round-robin arbiter that shares one updi_instruction_queue_handler between N instruction requesters (programming sequencer, debug/read engine, host bridge, …).
- Grants one requester at a time, latches its instruction payload, and pulses the handler's start.
- Tracks completion through the handler's ready signal and reports a per-requester done pulse.
- Supports a lock so one requester can issue an uninterrupted multi-instruction sequence (e.g. key write followed by status reads).

Parameters:
- N_REQ, 3, number of requesters (≥2).
- MAX_DATA_SIZE, 16, max data bytes per instruction; matches the handler.
- DATA_ADDR_BITS, $clog2(MAX_DATA_SIZE), width base for data_len.
- IDX_BITS, $clog2(N_REQ), owner index width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  N_REQ  level request per requester.
- req_lock  in  N_REQ  requester asks to keep ownership after its current instruction.
- req_opcode  in  N_REQ*8  packed opcodes; requester i at [8i+7:8i].
- req_data  in  [N_REQ][MAX_DATA_SIZE] x 8  per-requester data byte arrays.
- req_data_len  in  N_REQ*(DATA_ADDR_BITS+1)  packed byte counts.
- req_wait_ack_after  in  N_REQ*MAX_DATA_SIZE  packed ACK-wait masks.
- gnt  out  N_REQ  one-cycle pulse: request accepted and payload latched.
- done  out  N_REQ  one-cycle pulse: instruction fully completed by the handler.
- busy  out  1  arbiter not in IDLE.
- owner  out  IDX_BITS  index of current or last owner.
- hdl_start  out  1  start to the handler.
- hdl_ready  in  1  handler ready.
- hdl_opcode  out  8  latched opcode.
- hdl_data  out  [MAX_DATA_SIZE] x 8  latched data.
- hdl_data_len  out  DATA_ADDR_BITS+1  latched length.
- hdl_wait_ack_after  out  MAX_DATA_SIZE  latched ACK mask.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt, done, hdl_start, busy = 0; owner=0.
  - RR pointer=0; all hdl_* payload registers = 0.
- States: IDLE, START, RUN, LOCKED.
- IDLE:
  - If any req and hdl_ready=1, choose the first requester at or after the RR pointer, wrapping mod N_REQ.
  - On that edge: latch payload into hdl_*, set owner, pulse gnt[owner], go to START.
  - RR pointer becomes (owner+1) mod N_REQ.
  - With hdl_ready=0, no grant is made; requests wait.
- START: hdl_start=1 for exactly one cycle; next state RUN unconditionally.
- RUN:
  - hdl_start=0. Wait until hdl_ready=1; the handler drops ready the cycle after start.
  - The handler's ready returns only after its final ACK.
  - On the edge where hdl_ready=1: pulse done[owner] next cycle.
  - Go to LOCKED if req_lock[owner]=1, else IDLE.
- LOCKED:
  - Only the owner may be granted.
  - If req[owner]=1 and hdl_ready=1: latch, gnt, go to START. RR pointer is unchanged.
  - If req_lock[owner]=0 and req[owner]=0: go to IDLE.
  - Other requesters are ignored while locked.
- Grant latency: req seen in IDLE → gnt on next cycle, hdl_start on the cycle after.
- Payload latched only on grant. The requester must hold payload valid while req=1 until gnt; it may change afterwards.
- req still high after done counts as a new request and re-arbitrates under round-robin.
- Only one of gnt/done is asserted per cycle; done and gnt for the same requester are never in the same cycle.
- busy=1 in START, RUN and LOCKED.
- hdl_* outputs hold their latched values until the next grant.
- Reset mid-operation returns to IDLE immediately. Any handler activity is the handler's own reset concern; the arbiter raises no done.
- The arbiter does not route ACKs; waiting_for_ack/ack_received connect directly to the handler.

Test Plan:
- Single requester: N_REQ=3, req[1]=1, opcode 0xE5, len 0 → gnt[1] pulse, one-cycle hdl_start with hdl_opcode=0xE5; handler FIFO shows 0x55,0xE5; done[1] pulse after hdl_ready returns; owner=1.
- Simultaneous: req=3'b111, each requester holds req until its done → grant order 0,1,2,0; exactly one hdl_start per instruction.
- Lock: req[2] with lock=1 and opcode 0x45, data 12,34,56,78, ACK mask bits 1,3, req[0] also pending → after done[2], requester 2's next instruction is granted before 0; dropping lock lets 0 win next.
- Handler busy: hdl_ready=0 with req[0]=1 → no gnt for 10 cycles; gnt[0] the cycle after hdl_ready rises.
- Reset mid-RUN: rst low during RUN → busy=0, no done; after release, a fresh req[1] is granted normally with the pointer starting at 0.
- Payload hold: change req_opcode[0] to 0x00 after gnt[0] → hdl_opcode stays at the latched value through done.

Source files
------------

// File: rtl/updi_instruction_arbiter.sv
// ---------------------------------------------------------------------------
// updi_instruction_arbiter
//
// Round-robin arbiter sharing one UPDI instruction queue handler between
// N_REQ requesters. A granted requester's payload is latched into the hdl_*
// registers, the handler gets a one-cycle start, and completion (handler
// ready returning) is reported as a one-cycle done pulse to that requester.
// A requester holding req_lock keeps ownership across instructions.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req, req_lock       per-requester level request / keep-ownership
//   req_opcode          packed opcodes, requester i at [8i+7:8i]
//   req_data            per-requester data byte arrays
//   req_data_len        packed byte counts (DATA_ADDR_BITS+1 each)
//   req_wait_ack_after  packed ACK-wait masks (MAX_DATA_SIZE each)
//   gnt, done           one-cycle per-requester grant / completion pulses
//   busy, owner         not-idle flag, current or last owner index
//   hdl_start           one-cycle start to the handler
//   hdl_ready           handler ready
//   hdl_opcode, hdl_data, hdl_data_len, hdl_wait_ack_after  latched payload
// ---------------------------------------------------------------------------
module updi_instruction_arbiter #(
    parameter int N_REQ          = 3,
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int IDX_BITS       = $clog2(N_REQ)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_REQ-1:0]                            req,
    input  logic [N_REQ-1:0]                            req_lock,
    input  logic [N_REQ*8-1:0]                          req_opcode,
    input  logic [N_REQ-1:0][MAX_DATA_SIZE-1:0][7:0]    req_data,
    input  logic [N_REQ*(DATA_ADDR_BITS+1)-1:0]         req_data_len,
    input  logic [N_REQ*MAX_DATA_SIZE-1:0]              req_wait_ack_after,
    output logic [N_REQ-1:0]                            gnt,
    output logic [N_REQ-1:0]                            done,
    output logic                                        busy,
    output logic [IDX_BITS-1:0]                         owner,
    output logic                                        hdl_start,
    input  logic                                        hdl_ready,
    output logic [7:0]                                  hdl_opcode,
    output logic [MAX_DATA_SIZE-1:0][7:0]               hdl_data,
    output logic [DATA_ADDR_BITS:0]                     hdl_data_len,
    output logic [MAX_DATA_SIZE-1:0]                    hdl_wait_ack_after
);

    localparam int LW = DATA_ADDR_BITS + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [IDX_BITS-1:0]             owner_q, owner_d;
    logic [IDX_BITS-1:0]             ptr_q, ptr_d;
    logic [N_REQ-1:0]                gnt_q, gnt_d;
    logic [N_REQ-1:0]                done_q, done_d;
    logic                            hdl_start_q, hdl_start_d;
    logic [7:0]                      opc_q, opc_d;
    logic [MAX_DATA_SIZE-1:0][7:0]   data_q, data_d;
    logic [LW-1:0]                   len_q, len_d;
    logic [MAX_DATA_SIZE-1:0]        mask_q, mask_d;

    // Round-robin pick: lowest requesting index at or above the pointer,
    // otherwise lowest requesting index overall (wrap-around).
    logic                pick_vld, hi_vld;
    logic [IDX_BITS-1:0] pick_idx, hi_idx, lo_idx;

    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_vld = 1'b1;
                lo_idx   = IDX_BITS'(i);
                if (IDX_BITS'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = IDX_BITS'(i);
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Current owner's request / lock lines.
    logic own_req, own_lock;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_BITS'(i) == owner_q) begin
                own_req  = req[i];
                own_lock = req_lock[i];
            end
        end
    end

    logic                grant, fin;
    logic [IDX_BITS-1:0] grant_idx;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        done_d      = '0;
        hdl_start_d = 1'b0;
        opc_d       = opc_q;
        data_d      = data_q;
        len_d       = len_q;
        mask_d      = mask_q;
        grant       = 1'b0;
        fin         = 1'b0;
        grant_idx   = pick_idx;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld && hdl_ready) begin
                    grant   = 1'b1;
                    state_d = ST_START;
                    ptr_d   = (pick_idx == IDX_BITS'(N_REQ - 1)) ? '0
                                                                 : pick_idx + IDX_BITS'(1);
                end
            end
            ST_START: begin
                hdl_start_d = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // During the start cycle the handler has not yet seen start,
                // so its ready is stale; completion is only accepted after.
                if (hdl_ready && !hdl_start_q) begin
                    fin     = 1'b1;
                    state_d = own_lock ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                grant_idx = owner_q;
                if (own_req && hdl_ready) begin
                    grant   = 1'b1;
                    state_d = ST_START;
                end else if (!own_lock && !own_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            owner_d = grant_idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (IDX_BITS'(i) == grant_idx) begin
                    gnt_d[i] = 1'b1;
                    opc_d    = req_opcode[i*8 +: 8];
                    data_d   = req_data[i];
                    len_d    = req_data_len[i*LW +: LW];
                    mask_d   = req_wait_ack_after[i*MAX_DATA_SIZE +: MAX_DATA_SIZE];
                end
            end
        end

        if (fin) begin
            for (int i = 0; i < N_REQ; i++) begin
                done_d[i] = (IDX_BITS'(i) == owner_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            hdl_start_q <= 1'b0;
            opc_q       <= '0;
            data_q      <= '0;
            len_q       <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            hdl_start_q <= hdl_start_d;
            opc_q       <= opc_d;
            data_q      <= data_d;
            len_q       <= len_d;
            mask_q      <= mask_d;
        end
    end

    assign gnt                = gnt_q;
    assign done               = done_q;
    assign busy               = (state_q != ST_IDLE);
    assign owner              = owner_q;
    assign hdl_start          = hdl_start_q;
    assign hdl_opcode         = opc_q;
    assign hdl_data           = data_q;
    assign hdl_data_len       = len_q;
    assign hdl_wait_ack_after = mask_q;

endmodule

// File: tb/tb_updi_instruction_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for updi_instruction_arbiter: directed scenarios with a
// scoreboard of expected gnt/start/done events and a behavioural handler.
// ---------------------------------------------------------------------------
module tb_updi_instruction_arbiter;

    localparam int N  = 3;
    localparam int M  = 16;
    localparam int AB = 4;
    localparam int LW = AB + 1;
    localparam int IB = 2;

    typedef struct {
        logic [7:0]          opc;
        logic [LW-1:0]       len;
        logic [M-1:0][7:0]   data;
        logic [M-1:0]        mask;
        logic                lock;
    } instr_t;

    typedef struct {
        int     kind;   // 0 gnt, 1 start, 2 done
        int     idx;
        instr_t ins;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req, req_lock;
    logic [N*8-1:0]        req_opcode;
    logic [N-1:0][M-1:0][7:0] req_data;
    logic [N*LW-1:0]       req_data_len;
    logic [N*M-1:0]        req_wait_ack_after;
    logic [N-1:0]          gnt, done;
    logic                  busy;
    logic [IB-1:0]         owner;
    logic                  hdl_start, hdl_ready;
    logic [7:0]            hdl_opcode;
    logic [M-1:0][7:0]     hdl_data;
    logic [LW-1:0]         hdl_data_len;
    logic [M-1:0]          hdl_wait_ack_after;

    updi_instruction_arbiter #(.N_REQ(N), .MAX_DATA_SIZE(M)) dut (
        .clk(clk), .rst(rst_n), .req(req), .req_lock(req_lock),
        .req_opcode(req_opcode), .req_data(req_data), .req_data_len(req_data_len),
        .req_wait_ack_after(req_wait_ack_after), .gnt(gnt), .done(done),
        .busy(busy), .owner(owner), .hdl_start(hdl_start), .hdl_ready(hdl_ready),
        .hdl_opcode(hdl_opcode), .hdl_data(hdl_data), .hdl_data_len(hdl_data_len),
        .hdl_wait_ack_after(hdl_wait_ack_after)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    ev_t exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic instr_t mk(input logic [7:0] opc, input int len,
                                  input logic [7:0] d0, input logic [7:0] d1,
                                  input logic [7:0] d2, input logic [7:0] d3,
                                  input logic [M-1:0] mask, input logic lock);
        instr_t x;
        x.opc     = opc;
        x.len     = LW'(len);
        x.data    = '0;
        x.data[0] = d0;
        x.data[1] = d1;
        x.data[2] = d2;
        x.data[3] = d3;
        x.mask    = mask;
        x.lock    = lock;
        return x;
    endfunction

    // ---------------- handler model ----------------
    logic rdy_m = 1'b1;
    logic hold  = 1'b0;
    int   dly   = 4;
    int   hcnt  = 0;
    assign hdl_ready = rdy_m & ~hold;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rdy_m = 1'b1;
            hcnt  = 0;
        end else if (hdl_start) begin
            rdy_m = 1'b0;
            hcnt  = dly;
        end else if (hcnt > 0) begin
            hcnt--;
            if (hcnt == 0) rdy_m = 1'b1;
        end
    end

    // ---------------- requesters ----------------
    instr_t prog[N][8];
    int     head[N];
    int     tail[N];
    logic   inflight[N];

    task automatic push(input int i, input instr_t x, input bit with_done);
        ev_t e;
        prog[i][tail[i]] = x;
        tail[i]++;
        e.idx = i;
        e.ins = x;
        e.kind = 0; exp_q.push_back(e);
        e.kind = 1; exp_q.push_back(e);
        if (with_done) begin
            e.kind = 2; exp_q.push_back(e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst_n) begin
                if (done[i]) inflight[i] = 1'b0;
                if (gnt[i]) begin
                    inflight[i] = 1'b1;
                    req_lock[i] = prog[i][head[i]].lock;
                    head[i]++;
                end
            end
            if (head[i] < tail[i]) begin
                req_opcode[i*8 +: 8]          = prog[i][head[i]].opc;
                req_data[i]                   = prog[i][head[i]].data;
                req_data_len[i*LW +: LW]      = prog[i][head[i]].len;
                req_wait_ack_after[i*M +: M]  = prog[i][head[i]].mask;
            end else begin
                // Clobber the payload once granted: the latched copy must hold.
                req_opcode[i*8 +: 8] = 8'h00;
            end
            req[i] = (head[i] < tail[i]) || inflight[i];
        end
    end

    // ---------------- monitor ----------------
    task automatic mon_ev(input int kind);
        ev_t e;
        logic [N-1:0] oh;
        ncmp++;
        if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_event: got kind %0d gnt %b done %b want none at %0t",
                     kind, gnt, done, $time);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", 128'(kind), 128'(e.kind));
            oh = '0;
            oh[e.idx] = 1'b1;
            case (kind)
                0: begin
                    chk("gnt_vec", 128'(gnt), 128'(oh));
                    chk("gnt_owner", 128'(owner), 128'(e.idx));
                end
                1: begin
                    chk("start_opcode", 128'(hdl_opcode), 128'(e.ins.opc));
                    chk("start_len", 128'(hdl_data_len), 128'(e.ins.len));
                    chk("start_data", hdl_data, e.ins.data);
                    chk("start_mask", 128'(hdl_wait_ack_after), 128'(e.ins.mask));
                end
                default: begin
                    chk("done_vec", 128'(done), 128'(oh));
                    chk("done_opcode_held", 128'(hdl_opcode), 128'(e.ins.opc));
                end
            endcase
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if ((|gnt) || (|done)) chk("gnt_done_excl", 128'((|gnt) && (|done)), 128'(0));
            if (|done) mon_ev(2);
            if (|gnt) mon_ev(0);
            if (hdl_start) mon_ev(1);
        end
    end

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drained"}, 128'(exp_q.size()), 128'(0));
        chk({nm, "_idle"}, 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            inflight[i] = 1'b0;
        end
        req = '0;
        req_lock = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        int t;
        rst_n = 1'b0;
        req_opcode = '0;
        req_data = '0;
        req_data_len = '0;
        req_wait_ack_after = '0;
        clear_reqs();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_owner", 128'(owner), 128'(0));
        chk("rst_start", 128'(hdl_start), 128'(0));
        chk("rst_opcode", 128'(hdl_opcode), 128'(0));
        chk("rst_len", 128'(hdl_data_len), 128'(0));
        chk("rst_mask", 128'(hdl_wait_ack_after), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all three request; requester 0 has two instructions -> 0,1,2,0
        push(0, mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        push(1, mk(8'h05, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        push(2, mk(8'h06, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        exp_q.delete();
        begin
            ev_t e;
            int order[4] = '{0, 1, 2, 0};
            instr_t ins[4];
            ins[0] = mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0);
            ins[1] = mk(8'h05, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0);
            ins[2] = mk(8'h06, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0);
            ins[3] = mk(8'h07, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 16'h0001, 1'b0);
            prog[0][tail[0]] = ins[3];
            tail[0]++;
            for (int k = 0; k < 4; k++) begin
                e.idx = order[k];
                e.ins = ins[k];
                for (int j = 0; j < 3; j++) begin
                    e.kind = j;
                    exp_q.push_back(e);
                end
            end
        end
        wait_drain("rr");

        // single requester 1, opcode 0xE5, len 0 (pointer is 1 now)
        push(1, mk(8'hE5, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        wait_drain("single");
        chk("single_owner", 128'(owner), 128'(1));

        // lock: requester 2 keeps ownership although 0 is pending and the
        // pointer (2 -> 0 after first grant) would otherwise favour 0
        push(2, mk(8'h45, 4, 8'h12, 8'h34, 8'h56, 8'h78, 16'h000A, 1'b1), 1'b1);
        push(2, mk(8'h24, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        begin
            instr_t x;
            ev_t e;
            x = mk(8'h44, 1, 8'hAA, 8'h00, 8'h00, 8'h00, 16'h0001, 1'b0);
            prog[0][tail[0]] = x;
            tail[0]++;
            e.idx = 0;
            e.ins = x;
            for (int j = 0; j < 3; j++) begin
                e.kind = j;
                exp_q.push_back(e);
            end
        end
        wait_drain("lock");

        // handler busy: no grant while ready is low, grant right after it rises
        hold = 1'b1;
        push(0, mk(8'h08, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (|gnt) g++;
        end
        chk("busy_no_gnt", 128'(g), 128'(0));
        hold = 1'b0;
        @(negedge clk);
        chk("gnt_after_ready", 128'(gnt), 128'(3'b001));
        wait_drain("hbusy");

        // reset in the middle of RUN
        dly = 20;
        push(1, mk(8'h65, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b0);
        t = 0;
        while (!hdl_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midrun_start_seen", 128'(hdl_start), 128'(1));
        repeat (3) @(negedge clk);
        chk("midrun_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 128'(busy), 128'(0));
        chk("midrun_rst_owner", 128'(owner), 128'(0));
        chk("midrun_rst_done", 128'(done), 128'(0));
        chk("midrun_rst_opcode", 128'(hdl_opcode), 128'(0));
        exp_q.delete();
        clear_reqs();
        repeat (3) @(negedge clk);
        dly = 4;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // pointer restarts at 0, so 1 wins over 2
        push(1, mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        push(2, mk(8'h06, 0, 8'h00, 8'h00, 8'h00, 8'h00, '0, 1'b0), 1'b1);
        wait_drain("post_rst");
        chk("post_rst_owner", 128'(owner), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
